// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one memory request per PC address, waits for the
// response, buffers it across decode stalls and drives the IF/ID pipeline register.
module if_stage #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_pc_addr,
    input  logic              i_pc_valid,
    input  logic              i_flush,
    input  logic              i_stall,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_imem_req,
    input  logic [INST_W-1:0] i_imem_inst,
    input  logic              i_imem_valid,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_ifid_pc,
    output logic [INST_W-1:0] o_ifid_inst,
    output logic              o_ifid_valid
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] next_pc_p0;
    logic              req_vld_p0;
    logic              discard;
    logic              accept;
    logic [INST_W-1:0] hold_inst;
    logic              load_ifid;
    logic [INST_W-1:0] load_inst;
    logic [ADDR_W-1:0] ifid_pc_p1;
    logic [INST_W-1:0] ifid_inst_p1;
    logic              vld_p1;

    function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(4);
    endfunction

    // A new address is taken only when nothing is in flight or held.
    assign accept = (state == IDLE) && !req_vld_p0 && i_pc_valid;

    always_comb begin
        state_nxt = state;
        load_ifid = 1'b0;
        load_inst = hold_inst;
        case (state)
            IDLE: begin
                if (req_vld_p0) state_nxt = WAIT;
            end
            WAIT: begin
                if (i_imem_valid) begin
                    if (discard || i_flush) begin
                        state_nxt = IDLE;
                    end else if (i_stall) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = IDLE;
                        load_ifid = 1'b1;
                        load_inst = i_imem_inst;
                    end
                end
            end
            HOLD: begin
                if (i_flush) begin
                    state_nxt = IDLE;
                end else if (!i_stall) begin
                    state_nxt = IDLE;
                    load_ifid = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: fetch address capture and request issue
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            req_vld_p0 <= 1'b0;
            discard    <= 1'b0;
            fetch_addr <= '0;
            next_pc_p0 <= '0;
            hold_inst  <= '0;
        end else begin
            state      <= state_nxt;
            req_vld_p0 <= accept;
            if (accept) begin
                fetch_addr <= i_pc_addr;
                next_pc_p0 <= seq_pc(i_pc_addr);
            end
            // A flush once the request has gone out poisons whatever comes back.
            if (state == WAIT && i_imem_valid)
                discard <= 1'b0;
            else if ((req_vld_p0 || state == WAIT) && i_flush)
                discard <= 1'b1;
            if (state == WAIT && i_imem_valid && !discard && !i_flush && i_stall)
                hold_inst <= i_imem_inst;
        end
    end

    // p1: IF/ID pipeline register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1       <= 1'b0;
            ifid_pc_p1   <= '0;
            ifid_inst_p1 <= '0;
        end else if (i_flush) begin
            vld_p1 <= 1'b0;
        end else if (!i_stall) begin
            vld_p1 <= load_ifid;
            if (load_ifid) begin
                ifid_pc_p1   <= fetch_addr;
                ifid_inst_p1 <= load_inst;
            end
        end
    end

    assign o_imem_addr  = fetch_addr;
    assign o_imem_req   = req_vld_p0;
    assign o_next_pc    = next_pc_p0;
    assign o_busy       = (state != IDLE) || req_vld_p0;
    assign o_ifid_pc    = ifid_pc_p1;
    assign o_ifid_inst  = ifid_inst_p1;
    assign o_ifid_valid = vld_p1;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written flush/reset sequences,
// then randomized traffic against a transaction-level reference model.
module tb_if_stage;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [63:0] i_pc_addr = '0;
    logic        i_pc_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_stall = 1'b0;
    logic [63:0] o_imem_addr;
    logic        o_imem_req;
    logic [31:0] i_imem_inst = '0;
    logic        i_imem_valid = 1'b0;
    logic [63:0] o_next_pc;
    logic        o_busy;
    logic [63:0] o_ifid_pc;
    logic [31:0] o_ifid_inst;
    logic        o_ifid_valid;

    int checks = 0;
    int errors = 0;

    if_stage #(.INST_W(32), .ADDR_W(64)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pc_addr(i_pc_addr), .i_pc_valid(i_pc_valid),
        .i_flush(i_flush), .i_stall(i_stall), .o_imem_addr(o_imem_addr),
        .o_imem_req(o_imem_req), .i_imem_inst(i_imem_inst), .i_imem_valid(i_imem_valid),
        .o_next_pc(o_next_pc), .o_busy(o_busy), .o_ifid_pc(o_ifid_pc),
        .o_ifid_inst(o_ifid_inst), .o_ifid_valid(o_ifid_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst, pcv;
        logic [63:0] addr;
        logic        fl, st, mv;
        logic [31:0] inst;
        logic        e_req, e_busy, e_v;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic [63:0] e_npc, e_iaddr;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, busy, v, input logic [63:0] pc,
                           input logic [31:0] inst, input logic [63:0] npc, iaddr);
        chk({tag, ".req"},   o_imem_req, req);
        chk({tag, ".busy"},  o_busy, busy);
        chk({tag, ".valid"}, o_ifid_valid, v);
        chk({tag, ".pc"},    o_ifid_pc, pc);
        chk({tag, ".inst"},  o_ifid_inst, inst);
        chk({tag, ".npc"},   o_next_pc, npc);
        chk({tag, ".iaddr"}, o_imem_addr, iaddr);
    endtask

    task automatic cyc(input logic rst, pcv, input logic [63:0] addr, input logic fl, st, mv,
                       input logic [31:0] inst);
        i_rst = rst; i_pc_valid = pcv; i_pc_addr = addr; i_flush = fl;
        i_stall = st; i_imem_valid = mv; i_imem_inst = inst;
        @(posedge i_clk);
        #1;
    endtask

    task automatic add(input logic rst, pcv, input logic [63:0] addr, input logic fl, st, mv,
                       input logic [31:0] inst, input logic e_req, e_busy, e_v,
                       input logic [63:0] e_pc, input logic [31:0] e_inst,
                       input logic [63:0] e_npc, e_iaddr);
        vec_t r;
        r.rst = rst; r.pcv = pcv; r.addr = addr; r.fl = fl; r.st = st; r.mv = mv; r.inst = inst;
        r.e_req = e_req; r.e_busy = e_busy; r.e_v = e_v; r.e_pc = e_pc;
        r.e_inst = e_inst; r.e_npc = e_npc; r.e_iaddr = e_iaddr;
        vt.push_back(r);
    endtask

    // Reference model: tracks the fetch as a transaction (requested / outstanding /
    // poisoned / held) and the IF/ID entry decode sees.
    logic        m_req, m_out, m_drop, m_held, m_v;
    logic [63:0] m_fa, m_npc, m_pc;
    logic [31:0] m_hinst, m_inst;

    task automatic model_reset();
        m_req = 0; m_out = 0; m_drop = 0; m_held = 0; m_v = 0;
        m_fa = 0; m_npc = 0; m_pc = 0; m_hinst = 0; m_inst = 0;
    endtask

    task automatic model_step(input logic pcv, input logic [63:0] addr, input logic fl, st, mv,
                              input logic [31:0] inst);
        logic        ent = 0;
        logic [31:0] ent_inst = 0;
        if (m_req) begin
            m_req = 0; m_out = 1; m_drop = fl;
        end else if (m_out) begin
            if (mv) begin
                m_out = 0;
                if (!(m_drop || fl)) begin
                    if (st) begin m_held = 1; m_hinst = inst; end
                    else begin ent = 1; ent_inst = inst; end
                end
                m_drop = 0;
            end else if (fl) begin
                m_drop = 1;
            end
        end else if (m_held) begin
            if (fl) m_held = 0;
            else if (!st) begin m_held = 0; ent = 1; ent_inst = m_hinst; end
        end else if (pcv) begin
            m_fa = addr; m_npc = addr + 64'd4; m_req = 1;
        end
        if (fl) m_v = 0;
        else if (!st) begin
            if (ent) begin m_v = 1; m_pc = m_fa; m_inst = ent_inst; end
            else m_v = 0;
        end
    endtask

    localparam logic [31:0] I0 = 32'h0050_0093, IB = 32'h00A0_0113;
    localparam logic [31:0] IC = 32'h0030_8193, ID = 32'h0000_0013;
    localparam logic [63:0] WR = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        // rst pcv addr fl st mv inst | req busy v pc inst npc iaddr
        add(1,0,0,    0,0,0,0,  0,0,0,0,    0, 0,    0);
        add(0,1,0,    0,0,0,0,  1,1,0,0,    0, 4,    0);
        add(0,0,0,    0,0,0,0,  0,1,0,0,    0, 4,    0);
        add(0,0,0,    0,0,1,I0, 0,0,1,0,    I0,4,    0);
        add(0,0,0,    0,0,0,0,  0,0,0,0,    I0,4,    0);
        add(0,1,'h10, 0,0,0,0,  1,1,0,0,    I0,'h14, 'h10);
        for (int k = 0; k < 4; k++)
            add(0,0,0, 0,0,0,0,  0,1,0,0,   I0,'h14, 'h10);
        add(0,0,0,    0,0,1,IB, 0,0,1,'h10, IB,'h14, 'h10);
        add(0,0,0,    0,1,0,0,  0,0,1,'h10, IB,'h14, 'h10);
        add(0,1,'h20, 0,1,0,0,  1,1,1,'h10, IB,'h24, 'h20);
        add(0,0,0,    0,1,0,0,  0,1,1,'h10, IB,'h24, 'h20);
        add(0,0,0,    0,1,1,IC, 0,1,1,'h10, IB,'h24, 'h20);
        add(0,0,0,    0,1,0,0,  0,1,1,'h10, IB,'h24, 'h20);
        add(0,0,0,    0,0,0,0,  0,0,1,'h20, IC,'h24, 'h20);
        add(0,0,0,    0,0,0,0,  0,0,0,'h20, IC,'h24, 'h20);
        add(0,1,WR,   0,0,0,0,  1,1,0,'h20, IC,0,    WR);
        add(0,0,0,    0,0,0,0,  0,1,0,'h20, IC,0,    WR);
        add(0,0,0,    0,0,1,ID, 0,0,1,WR,   ID,0,    WR);
        add(0,0,0,    0,0,0,0,  0,0,0,WR,   ID,0,    WR);

        foreach (vt[i]) begin
            cyc(vt[i].rst, vt[i].pcv, vt[i].addr, vt[i].fl, vt[i].st, vt[i].mv, vt[i].inst);
            chk_all($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_busy, vt[i].e_v, vt[i].e_pc,
                    vt[i].e_inst, vt[i].e_npc, vt[i].e_iaddr);
        end

        // Flush while waiting: the response for 0x30 is dropped, 0x100 proceeds.
        cyc(0,1,'h30,0,0,0,0);  chk("flw.req", o_imem_req, 1); chk("flw.npc", o_next_pc, 'h34);
        cyc(0,0,0,0,0,0,0);     chk("flw.busy1", o_busy, 1);
        cyc(0,0,0,1,0,0,0);     chk("flw.busy2", o_busy, 1); chk("flw.v1", o_ifid_valid, 0);
        cyc(0,0,0,0,0,1,32'hDEAD_BEEF);
        chk("flw.v2", o_ifid_valid, 0); chk("flw.busy3", o_busy, 0);
        cyc(0,1,'h100,0,0,0,0); chk("flw.req2", o_imem_req, 1); chk("flw.iaddr", o_imem_addr, 'h100);
        cyc(0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,1,32'h1111_1111);
        chk("flw.v3", o_ifid_valid, 1); chk("flw.pc", o_ifid_pc, 'h100);
        chk("flw.inst", o_ifid_inst, 32'h1111_1111);

        // Flush coincident with the memory response.
        cyc(0,1,'h200,0,0,0,0);
        cyc(0,0,0,0,0,0,0);
        cyc(0,0,0,1,0,1,32'h2222_2222);
        chk("flc.v", o_ifid_valid, 0); chk("flc.busy", o_busy, 0);
        chk("flc.inst", o_ifid_inst, 32'h1111_1111);
        cyc(0,1,'h240,0,0,0,0); chk("flc.req", o_imem_req, 1);
        cyc(0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,1,32'h2424_2424);
        chk("flc.v2", o_ifid_valid, 1); chk("flc.pc", o_ifid_pc, 'h240);

        // Flush while holding a stalled instruction.
        cyc(0,1,'h300,0,0,0,0);
        cyc(0,0,0,0,0,0,0);
        cyc(0,0,0,0,1,1,32'h3333_3333); chk("flh.busy", o_busy, 1); chk("flh.v", o_ifid_valid, 0);
        cyc(0,0,0,1,1,0,0);             chk("flh.v2", o_ifid_valid, 0); chk("flh.busy2", o_busy, 0);
        cyc(0,0,0,0,0,0,0);             chk("flh.v3", o_ifid_valid, 0);
        chk("flh.inst", o_ifid_inst, 32'h2424_2424);

        // Reset mid-fetch, then a late response that must be ignored.
        cyc(0,1,'h400,0,0,0,0);
        cyc(0,0,0,0,0,0,0);
        cyc(1,0,0,0,0,0,0);
        chk_all("rstw", 0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,1,32'h4444_4444);
        chk_all("late", 0,0,0,0,0,0,0);

        // Randomized traffic with a responsive memory of 1..4 cycles extra latency.
        cyc(1,0,0,0,0,0,0);
        model_reset();
        begin
            int          mem_cnt = 0;
            logic        pcv, fl, st, mv;
            logic [63:0] addr;
            logic [31:0] inst;
            for (int n = 0; n < 3000; n++) begin
                mv = 0;
                inst = $urandom;
                if (mem_cnt > 0) begin
                    mem_cnt--;
                    if (mem_cnt == 0) mv = 1;
                end
                pcv  = ($urandom_range(0, 2) == 0);
                addr = ($urandom_range(0, 15) == 0) ? WR : {$urandom, $urandom & 32'hFFFF_FFFC};
                fl   = ($urandom_range(0, 11) == 0);
                st   = ($urandom_range(0, 2) == 0);
                model_step(pcv, addr, fl, st, mv, inst);
                cyc(0, pcv, addr, fl, st, mv, inst);
                if (m_req) mem_cnt = $urandom_range(2, 5);
                chk_all($sformatf("rnd%0d", n), m_req, m_req || m_out || m_held, m_v, m_pc,
                        m_inst, m_npc, m_fa);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
